mvm_seq_ctrl: RTL
=================

MVM_SEQ_CTRL -- requirements
Module: mvm_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  begin a new 4x4 matrix-vector job.
REQ-004 SHALL have ports: in_valid  in  1  data_in word present this cycle.
REQ-005 SHALL have ports: in_ready  out  1  high in LOAD_X/LOAD_A only.
REQ-006 SHALL have ports: wr_en_x, wr_en_a  out  1 each  x/A memory write enables (= in_valid & state).
REQ-007 SHALL have ports: addr_x0..addr_x3  out  6 each  x read/write addresses.
REQ-008 SHALL have ports: addr_a0..addr_a3  out  6 each  A read/write addresses.
REQ-009 SHALL have ports: addr_y  out  6  y memory address (write in COMPUTE/DRAIN, read in output phase).
REQ-010 SHALL have ports: wr_en_y  out  1  y memory write enable.
REQ-011 SHALL have ports: out_valid  out  1  y memory data_out holds a result.
REQ-012 SHALL have ports: out_idx  out  2  index of result under out_valid.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse at output-phase start.

Function
REQ-014 Main FSM states SHALL be IDLE, LOAD_X, LOAD_A, COMPUTE, DRAIN, OUTPUT.
REQ-015 Transitions SHALL be: IDLE->LOAD_X on start; LOAD_X->LOAD_A after 4th accepted word; LOAD_A->COMPUTE after 16th; COMPUTE->DRAIN after 4 cycles; DRAIN->OUTPUT after 2 cycles; OUTPUT->IDLE after 5 cycles.
REQ-016 Load phases SHALL accept one word per cycle only when in_valid=1; in_valid gaps stall the word counter; write address = count (x: 0..3, A: 0..15 row-major), on addr_x0/addr_a0.
REQ-017 Outside LOAD_X, addr_x0..3 SHALL be 0,1,2,3.
REQ-018 COMPUTE cycle k (k=0..3) SHALL drive addr_a0..3 = 4k, 4k+1, 4k+2, 4k+3.
REQ-019 Datapath latency SHALL be 2 cycles (memory read + multiplier register; adder combinational): wr_en_y=1 with addr_y=0,1,2,3 in COMPUTE cycles 2,3 and DRAIN cycles 0,1; wr_en_y=0 otherwise.
REQ-020 Output phase cycle j (j=0..3) SHALL drive addr_y=j with wr_en_y=0.
REQ-021 out_valid SHALL be high in output cycles 1..4, with out_idx=j-1.
REQ-022 done SHALL be high exactly in output cycle 0.
REQ-023 start outside IDLE SHALL be ignored unless REQ-029 applies.
REQ-024 All counters SHALL be 5 bits unsigned; no counter SHALL wrap past its terminal value.

Reset
REQ-025 reset SHALL asynchronously force state=IDLE and clear all counters.
REQ-026 During reset, all enables, in_ready, out_valid and done SHALL be 0, and every address SHALL be 0 except addr_x0..3=0,1,2,3.
REQ-027 Reset mid-job SHALL abort with no further memory writes; the next job SHALL require a fresh start.

Configuration
REQ-028 Macro MVM_IO_OVERLAP_EN SHALL select output overlap.
REQ-029 With MVM_IO_OVERLAP_EN defined, the output phase SHALL run as an independent sub-sequencer. DRAIN SHALL go to IDLE and launch it. start SHALL be accepted in the same cycle, with LOAD_X overlapping the output phase. The y memory SHALL never see a write during the output phase; loading takes at least 20 cycles, which exceeds the 5 output cycles.
REQ-030 Without MVM_IO_OVERLAP_EN, behaviour SHALL be REQ-014..023 exactly, and start SHALL be ignored until IDLE.

Verification
REQ-031 Reset; start; stream 0..19 with in_valid=1 -> done 27 cycles after start sampled; out_valid results 38, 62, 86, 110 with out_idx 0..3.
REQ-032 Repeat the job with data 10..29 -> results 718, 902, 1086, 1270.
REQ-033 Job with in_valid low every other cycle -> same results as REQ-031; in_ready high throughout the loads; exactly 20 x/A writes.
REQ-034 Assert reset for 1 cycle during COMPUTE cycle 1 -> state IDLE immediately; wr_en_y never asserted afterwards; no done.
REQ-035 start pulsed during COMPUTE -> ignored, with no change to the sequence.
REQ-036 With MVM_IO_OVERLAP_EN, start asserted in output cycle 0 -> LOAD_X begins next cycle; first-job results unchanged; second job correct.

Source files
------------

// File: rtl/mvm_seq_ctrl.sv
// Sequencer for a 4x4 matrix-vector job: loads x and A, steps compute, writes y, replays y.
// Latency: start to done is 27 cycles with no input gaps; the datapath adds 2 cycles (read + mul register).
// Backpressure: loads stall on in_valid=0; start is ignored outside IDLE. Option macro: MVM_IO_OVERLAP_EN.
module mvm_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       wr_en_x,
    output logic       wr_en_a,
    output logic [5:0] addr_x0,
    output logic [5:0] addr_x1,
    output logic [5:0] addr_x2,
    output logic [5:0] addr_x3,
    output logic [5:0] addr_a0,
    output logic [5:0] addr_a1,
    output logic [5:0] addr_a2,
    output logic [5:0] addr_a3,
    output logic [5:0] addr_y,
    output logic       wr_en_y,
    output logic       out_valid,
    output logic [1:0] out_idx,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_X, S_LOAD_A, S_COMPUTE, S_DRAIN, S_OUTPUT
    } state_t;

    // Terminal counts; every counter stops here and never wraps.
    localparam logic [4:0] X_LAST = 5'd3;
    localparam logic [4:0] A_LAST = 5'd15;
    localparam logic [4:0] C_LAST = 5'd3;
    localparam logic [4:0] D_LAST = 5'd1;
    localparam logic [4:0] O_LAST = 5'd4;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic       r_oact;
    logic [4:0] r_ocnt;
    logic       r_ld_x;
    logic       r_ld_a;
    logic [5:0] r_addr_x0;
    logic [5:0] r_addr_a0;
    logic [5:0] r_addr_a1;
    logic [5:0] r_addr_a2;
    logic [5:0] r_addr_a3;
    logic [5:0] r_addr_y;
    logic       r_wr_en_y;
    logic       r_out_valid;
    logic [1:0] r_out_idx;
    logic       r_done;

    state_t     w_state_nxt;
    logic [4:0] w_cnt_nxt;
    logic       w_oact_nxt;
    logic [4:0] w_ocnt_nxt;
    logic [5:0] w_base;
    logic       w_ld_x;
    logic       w_ld_a;
    logic [5:0] w_addr_x0;
    logic [5:0] w_addr_a0;
    logic [5:0] w_addr_a1;
    logic [5:0] w_addr_a2;
    logic [5:0] w_addr_a3;
    logic [5:0] w_addr_y;
    logic       w_wr_en_y;
    logic       w_out_valid;
    logic [1:0] w_out_idx;
    logic       w_done;

    // Next state of the main sequencer and of the output-phase sub-sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_oact_nxt  = r_oact;
        w_ocnt_nxt  = r_ocnt;

        // Output phase: cycle 0 raises done, cycles 1..4 present y[0..3].
        if (r_oact) begin
            if (r_ocnt == O_LAST) begin
                w_oact_nxt = 1'b0;
                w_ocnt_nxt = 5'd0;
            end else begin
                w_ocnt_nxt = r_ocnt + 5'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_X;
                    w_cnt_nxt   = 5'd0;
                end
            end
            S_LOAD_X: begin
                if (in_valid) begin
                    if (r_cnt == X_LAST) begin
                        w_state_nxt = S_LOAD_A;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
            S_LOAD_A: begin
                if (in_valid) begin
                    if (r_cnt == A_LAST) begin
                        w_state_nxt = S_COMPUTE;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
            S_COMPUTE: begin
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == D_LAST) begin
                    w_cnt_nxt  = 5'd0;
                    w_oact_nxt = 1'b1;
                    w_ocnt_nxt = 5'd0;
`ifdef MVM_IO_OVERLAP_EN
                    // Output replays on its own; the main FSM is free for the next start.
                    w_state_nxt = S_IDLE;
`else
                    w_state_nxt = S_OUTPUT;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_OUTPUT: begin
                if (!w_oact_nxt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    assign w_base = {1'b0, w_cnt_nxt} << 2;

    // Output decode from next-state values so that every output leaves a flop.
    always_comb begin
        w_ld_x      = (w_state_nxt == S_LOAD_X);
        w_ld_a      = (w_state_nxt == S_LOAD_A);
        w_addr_x0   = 6'd0;
        w_addr_a0   = 6'd0;
        w_addr_a1   = 6'd0;
        w_addr_a2   = 6'd0;
        w_addr_a3   = 6'd0;
        w_addr_y    = 6'd0;
        w_wr_en_y   = 1'b0;
        w_out_valid = 1'b0;
        w_out_idx   = 2'd0;
        w_done      = 1'b0;

        case (w_state_nxt)
            S_LOAD_X: w_addr_x0 = {1'b0, w_cnt_nxt};
            S_LOAD_A: w_addr_a0 = {1'b0, w_cnt_nxt};
            S_COMPUTE: begin
                // Row k of A against all of x.
                w_addr_a0 = w_base;
                w_addr_a1 = w_base + 6'd1;
                w_addr_a2 = w_base + 6'd2;
                w_addr_a3 = w_base + 6'd3;
                // Row k lands two cycles after its read.
                if (w_cnt_nxt >= 5'd2) begin
                    w_wr_en_y = 1'b1;
                    w_addr_y  = {1'b0, w_cnt_nxt} - 6'd2;
                end
            end
            S_DRAIN: begin
                w_wr_en_y = 1'b1;
                w_addr_y  = {1'b0, w_cnt_nxt} + 6'd2;
            end
            default: ;
        endcase

        // y read address leads out_valid by one cycle (synchronous y read).
        if (w_oact_nxt) begin
            case (w_ocnt_nxt)
                5'd0: begin w_done = 1'b1; w_addr_y = 6'd0; end
                5'd1: begin w_out_valid = 1'b1; w_out_idx = 2'd0; w_addr_y = 6'd1; end
                5'd2: begin w_out_valid = 1'b1; w_out_idx = 2'd1; w_addr_y = 6'd2; end
                5'd3: begin w_out_valid = 1'b1; w_out_idx = 2'd2; w_addr_y = 6'd3; end
                5'd4: begin w_out_valid = 1'b1; w_out_idx = 2'd3; end
                default: ;
            endcase
        end
    end

    // State, counters and registered outputs; reset aborts any job at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_oact      <= 1'b0;
            r_ocnt      <= 5'd0;
            r_ld_x      <= 1'b0;
            r_ld_a      <= 1'b0;
            r_addr_x0   <= 6'd0;
            r_addr_a0   <= 6'd0;
            r_addr_a1   <= 6'd0;
            r_addr_a2   <= 6'd0;
            r_addr_a3   <= 6'd0;
            r_addr_y    <= 6'd0;
            r_wr_en_y   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= 2'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_oact      <= w_oact_nxt;
            r_ocnt      <= w_ocnt_nxt;
            r_ld_x      <= w_ld_x;
            r_ld_a      <= w_ld_a;
            r_addr_x0   <= w_addr_x0;
            r_addr_a0   <= w_addr_a0;
            r_addr_a1   <= w_addr_a1;
            r_addr_a2   <= w_addr_a2;
            r_addr_a3   <= w_addr_a3;
            r_addr_y    <= w_addr_y;
            r_wr_en_y   <= w_wr_en_y;
            r_out_valid <= w_out_valid;
            r_out_idx   <= w_out_idx;
            r_done      <= w_done;
        end
    end

    assign in_ready  = r_ld_x | r_ld_a;
    assign wr_en_x   = in_valid & r_ld_x;
    assign wr_en_a   = in_valid & r_ld_a;
    assign addr_x0   = r_addr_x0;
    assign addr_x1   = 6'd1;
    assign addr_x2   = 6'd2;
    assign addr_x3   = 6'd3;
    assign addr_a0   = r_addr_a0;
    assign addr_a1   = r_addr_a1;
    assign addr_a2   = r_addr_a2;
    assign addr_a3   = r_addr_a3;
    assign addr_y    = r_addr_y;
    assign wr_en_y   = r_wr_en_y;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign done      = r_done;

endmodule
